// File: rtl/mem_copy_master.sv
`default_nettype none
// ============================================================================
//  Module      : mem_copy_master
//  Description : Native-bus (valid/ready) initiator that copies a block of
//                32-bit words from a source to a destination address in the
//                unified RAM, one read followed by one write per word.
//  Ports       : clk, resetn          - clock, async active-low reset
//                start, src_addr, dst_addr, len_words - copy request
//                busy, done, error, words_done        - status
//                mem_valid/mem_instr/mem_ready/mem_addr/mem_wdata/
//                mem_wstrb/mem_rdata                  - requester-side bus
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_copy_master #(
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_WIDTH-1:0] len_words,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [LEN_WIDTH-1:0] words_done,
    output logic                 mem_valid,
    output logic                 mem_instr,
    input  logic                 mem_ready,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_wstrb,
    input  logic [31:0]          mem_rdata
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RD   = 2'd1;
    localparam logic [1:0] c_WR   = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    // Wait counter only has to reach TIMEOUT_CYCLES-1; keep at least 1 bit
    // so the design stays legal when the timeout is disabled or tiny.
    localparam int c_WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST =
        c_WAIT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    logic [1:0]           r_state;
    logic [31:0]          r_src_ptr;
    logic [31:0]          r_dst_ptr;
    logic [LEN_WIDTH-1:0] r_len;
    logic [LEN_WIDTH-1:0] r_words_done;
    logic [c_WAIT_W-1:0]  r_wait;
    logic                 r_error;
    logic                 r_mem_valid;
    logic [31:0]          r_mem_addr;
    logic [31:0]          r_mem_wdata;
    logic [3:0]           r_mem_wstrb;

    logic                 w_timeout;
    logic [LEN_WIDTH-1:0] w_words_next;
    logic                 w_misaligned;

    // Current request has waited its full budget and still sees no ready.
    assign w_timeout    = (TIMEOUT_CYCLES != 0) && (r_wait == c_WAIT_LAST);
    assign w_words_next = r_words_done + 1'b1;
    assign w_misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= c_IDLE;
            r_src_ptr    <= 32'd0;
            r_dst_ptr    <= 32'd0;
            r_len        <= '0;
            r_words_done <= '0;
            r_wait       <= '0;
            r_error      <= 1'b0;
            r_mem_valid  <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 32'd0;
            r_mem_wstrb  <= 4'h0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_error      <= 1'b0;
                        r_words_done <= '0;
                        r_src_ptr    <= src_addr;
                        r_dst_ptr    <= dst_addr;
                        r_len        <= len_words;
                        r_wait       <= '0;
                        if (w_misaligned) begin
                            r_error <= 1'b1;
                            r_state <= c_DONE;
                        end else if (len_words == '0) begin
                            r_state <= c_DONE;
                        end else begin
                            // First read is presented straight away.
                            r_mem_valid <= 1'b1;
                            r_mem_addr  <= src_addr;
                            r_mem_wstrb <= 4'h0;
                            r_state     <= c_RD;
                        end
                    end
                end

                c_RD: begin
                    if (mem_ready) begin
                        // Read data goes straight into the write-data register,
                        // so the write request follows without a bubble.
                        r_mem_wdata <= mem_rdata;
                        r_mem_addr  <= r_dst_ptr;
                        r_mem_wstrb <= 4'hF;
                        r_wait      <= '0;
                        r_state     <= c_WR;
                    end else if (w_timeout) begin
                        r_mem_valid <= 1'b0;
                        r_mem_wstrb <= 4'h0;
                        r_error     <= 1'b1;
                        r_state     <= c_DONE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end

                c_WR: begin
                    if (mem_ready) begin
                        r_words_done <= w_words_next;
                        r_src_ptr    <= r_src_ptr + 32'd4;
                        r_dst_ptr    <= r_dst_ptr + 32'd4;
                        r_wait       <= '0;
                        r_mem_wstrb  <= 4'h0;
                        if (w_words_next == r_len) begin
                            r_mem_valid <= 1'b0;
                            r_state     <= c_DONE;
                        end else begin
                            r_mem_addr <= r_src_ptr + 32'd4;
                            r_state    <= c_RD;
                        end
                    end else if (w_timeout) begin
                        r_mem_valid <= 1'b0;
                        r_mem_wstrb <= 4'h0;
                        r_error     <= 1'b1;
                        r_state     <= c_DONE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end

                c_DONE: begin
                    r_state <= c_IDLE;
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy       = (r_state == c_RD) || (r_state == c_WR);
    assign done       = (r_state == c_DONE);
    assign error      = r_error;
    assign words_done = r_words_done;
    assign mem_valid  = r_mem_valid;
    assign mem_instr  = 1'b0;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_wstrb  = r_mem_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_copy_master
//  Description : Self-checking bench for mem_copy_master with a RAM responder
//                (programmable latency / stall) and a word-array copy model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_copy_master;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len_words;
    logic        busy, done, error;
    logic [15:0] words_done;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    always #5 clk = ~clk;

    mem_copy_master #(.LEN_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
        .busy(busy), .done(done), .error(error), .words_done(words_done),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata)
    );

    // 4 KiB RAM window; address bits above 11 alias, which also exercises wrap.
    logic [31:0] ram  [0:1023];
    logic [31:0] expm [0:1023];

    int  checks = 0;
    int  failures = 0;
    int  fix_lat = 0;
    bit  rand_lat = 1'b0;
    int  stall_rd = -1;
    bit  clr = 1'b0;

    int  cur_lat = 0, wcnt = 0, n_rd = 0, n_wr = 0, n_valid = 0;
    int  stab_viol = 0, run = 0, last_stall = 0;
    logic        p_wait = 1'b0;
    logic [31:0] p_addr = 32'd0, p_wdata = 32'd0;
    logic [3:0]  p_wstrb = 4'h0;
    logic [31:0] hs_addr[$];
    logic [31:0] hs_data[$];
    logic [3:0]  hs_wstrb[$];

    assign mem_ready = mem_valid && (wcnt >= cur_lat) &&
                       !(stall_rd >= 0 && mem_wstrb == 4'h0 && n_rd == stall_rd);
    assign mem_rdata = ram[mem_addr[11:2]];

    // Responder + bus monitor
    always @(posedge clk) begin
        if (clr) begin
            n_rd <= 0; n_wr <= 0; n_valid <= 0; stab_viol <= 0; run <= 0; last_stall <= 0;
        end else begin
            if (mem_valid) n_valid <= n_valid + 1;
            if (p_wait && mem_valid &&
                (mem_addr !== p_addr || mem_wdata !== p_wdata || mem_wstrb !== p_wstrb))
                stab_viol <= stab_viol + 1;
            if (mem_valid && mem_ready) begin
                run <= 0;
                hs_addr.push_back(mem_addr);
                hs_data.push_back(mem_wdata);
                hs_wstrb.push_back(mem_wstrb);
                if (mem_wstrb == 4'hF) begin
                    n_wr <= n_wr + 1;
                    ram[mem_addr[11:2]] = mem_wdata;
                end else begin
                    n_rd <= n_rd + 1;
                end
            end else if (mem_valid) begin
                run <= run + 1;
            end else begin
                if (run > 0) last_stall <= run;
                run <= 0;
            end
        end
        p_wait  <= mem_valid && !mem_ready;
        p_addr  <= mem_addr;
        p_wdata <= mem_wdata;
        p_wstrb <= mem_wstrb;
        if (!mem_valid || mem_ready) begin
            wcnt    <= 0;
            cur_lat <= rand_lat ? int'($urandom_range(0, 3)) : fix_lat;
        end else begin
            wcnt <= wcnt + 1;
        end
    end

    function automatic int idx(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    function automatic void snapshot();
        for (int i = 0; i < 1024; i++) expm[i] = ram[i];
    endfunction

    // Reference: word-by-word ascending copy applied to the snapshot.
    function automatic void model_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++)
            expm[idx(d + 32'(4 * i))] = expm[idx(s + 32'(4 * i))];
    endfunction

    function automatic int mem_mismatches();
        int m = 0;
        for (int i = 0; i < 1024; i++) if (ram[i] !== expm[i]) m++;
        return m;
    endfunction

    // Expected bus trace: read src+4i, then write dst+4i with the copied word.
    function automatic int log_mismatches(input logic [31:0] s, input logic [31:0] d, input int n);
        int m = 0;
        logic [31:0] a;
        if (hs_addr.size() != 2 * n) m++;
        for (int i = 0; i < n; i++) begin
            if (2 * i + 1 < hs_addr.size()) begin
                a = s + 32'(4 * i);
                if (hs_addr[2*i] !== a || hs_wstrb[2*i] !== 4'h0) m++;
                a = d + 32'(4 * i);
                if (hs_addr[2*i+1] !== a || hs_wstrb[2*i+1] !== 4'hF ||
                    hs_data[2*i+1] !== expm[idx(a)]) m++;
            end
        end
        return m;
    endfunction

    task automatic kick(input logic [31:0] s, input logic [31:0] d, input int n);
        @(negedge clk);
        hs_addr.delete(); hs_data.delete(); hs_wstrb.delete();
        src_addr = s; dst_addr = d; len_words = 16'(n);
        start = 1'b1; clr = 1'b1;
        @(negedge clk);
        start = 1'b0; clr = 1'b0;
    endtask

    // Returns the cycle (counted from the accepting edge) in which done is seen.
    task automatic wait_done(input string name, output int cyc);
        cyc = 1;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_done_timeout: done=%0b after %0d cycles, required done=1", name, done, cyc);
        end
    endtask

    task automatic run_copy(input string name, input logic [31:0] s, input logic [31:0] d,
                            input int n, output int cyc, output logic busy1);
        kick(s, d, n);
        busy1 = busy;
        wait_done(name, cyc);
    endtask

    task automatic test_reset();
        int cyc;
        resetn = 1'b0; start = 1'b0; src_addr = 0; dst_addr = 0; len_words = 0;
        for (int i = 0; i < 1024; i++) ram[i] = $urandom;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_valid, mem_addr, mem_wdata, mem_wstrb, busy, done, error, words_done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%0b addr=%h wdata=%h wstrb=%h busy=%0b done=%0b err=%0b wd=%0d, required all 0",
                     mem_valid, mem_addr, mem_wdata, mem_wstrb, busy, done, error, words_done);
        end
        checks++;
        if (mem_instr !== 1'b0) begin
            failures++;
            $display("FAIL reset_instr: mem_instr=%0b required 0", mem_instr);
        end
        resetn = 1'b1;
        cyc = 0;
    endtask

    task automatic test_basic();
        int cyc; logic b1; int m;
        fix_lat = 0; rand_lat = 1'b0; stall_rd = -1;
        for (int i = 0; i < 4; i++) ram[idx(32'h100) + i] = 32'hA000_0000 | $urandom_range(0, 65535);
        snapshot(); model_copy(32'h100, 32'h200, 4);
        run_copy("basic", 32'h100, 32'h200, 4, cyc, b1);
        checks++;
        if (cyc != 9) begin failures++; $display("FAIL basic_latency: done at cycle %0d, required 9", cyc); end
        checks++;
        if (b1 !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL basic_busy: busy_after_start=%0b busy_in_done=%0b, required 1/0", b1, busy);
        end
        checks++;
        if (error !== 1'b0 || words_done !== 16'd4) begin
            failures++; $display("FAIL basic_status: error=%0b words_done=%0d, required 0/4", error, words_done);
        end
        m = log_mismatches(32'h100, 32'h200, 4);
        checks++;
        if (m != 0) begin failures++; $display("FAIL basic_bus_trace: %0d bad handshakes of %0d, required 0 of 8", m, hs_addr.size()); end
        m = mem_mismatches();
        checks++;
        if (m != 0) begin failures++; $display("FAIL basic_ram: %0d words differ, required 0", m); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse: done=%0b one cycle later, required 0", done); end
    endtask

    task automatic test_wait_states();
        int cyc; logic b1; int m;
        fix_lat = 3; rand_lat = 1'b0; stall_rd = -1;
        snapshot(); model_copy(32'h300, 32'h380, 2);
        run_copy("wait", 32'h300, 32'h380, 2, cyc, b1);
        checks++;
        if (stab_viol != 0) begin failures++; $display("FAIL wait_stable: %0d unstable waiting cycles, required 0", stab_viol); end
        checks++;
        if (n_valid != 16 || cyc != 17) begin
            failures++; $display("FAIL wait_timing: valid_cycles=%0d done_cycle=%0d, required 16/17", n_valid, cyc);
        end
        m = log_mismatches(32'h300, 32'h380, 2) + mem_mismatches();
        checks++;
        if (m != 0 || error !== 1'b0) begin failures++; $display("FAIL wait_copy: %0d mismatches error=%0b, required 0/0", m, error); end
    endtask

    task automatic test_random();
        int cyc; logic b1; int m; int n;
        logic [31:0] s, d;
        fix_lat = 0; rand_lat = 1'b1; stall_rd = -1;
        for (int it = 0; it < 6; it++) begin
            s = 32'h400 + 32'(4 * $urandom_range(0, 63));
            d = 32'h400 + 32'(4 * $urandom_range(0, 63));
            n = int'($urandom_range(1, 12));
            snapshot(); model_copy(s, d, n);
            run_copy("random", s, d, n, cyc, b1);
            m = log_mismatches(s, d, n) + mem_mismatches();
            checks++;
            if (m != 0) begin failures++; $display("FAIL random_copy[%0d]: src=%h dst=%h len=%0d mismatches=%0d, required 0", it, s, d, n, m); end
            checks++;
            if (error !== 1'b0 || words_done !== 16'(n) || stab_viol != 0) begin
                failures++; $display("FAIL random_status[%0d]: error=%0b words_done=%0d unstable=%0d, required 0/%0d/0", it, error, words_done, stab_viol, n);
            end
        end
        rand_lat = 1'b0;
    endtask

    task automatic test_misalign();
        int cyc; logic b1;
        fix_lat = 0; stall_rd = -1;
        run_copy("misalign_src", 32'h102, 32'h200, 5, cyc, b1);
        checks++;
        if (cyc != 1 || n_valid != 0 || error !== 1'b1 || words_done !== 16'd0) begin
            failures++; $display("FAIL misalign_src: done_cycle=%0d valid_cycles=%0d error=%0b wd=%0d, required 1/0/1/0", cyc, n_valid, error, words_done);
        end
        run_copy("misalign_dst", 32'h100, 32'h201, 3, cyc, b1);
        checks++;
        if (cyc != 1 || n_valid != 0 || error !== 1'b1) begin
            failures++; $display("FAIL misalign_dst: done_cycle=%0d valid_cycles=%0d error=%0b, required 1/0/1", cyc, n_valid, error);
        end
        run_copy("zero_len", 32'h100, 32'h200, 0, cyc, b1);
        checks++;
        if (cyc != 1 || n_valid != 0 || error !== 1'b0 || words_done !== 16'd0) begin
            failures++; $display("FAIL zero_len: done_cycle=%0d valid_cycles=%0d error=%0b wd=%0d, required 1/0/0/0", cyc, n_valid, error, words_done);
        end
    endtask

    task automatic test_timeout();
        int cyc; logic b1; int m;
        fix_lat = 0; rand_lat = 1'b0; stall_rd = 1;
        snapshot(); model_copy(32'h100, 32'h240, 1);
        run_copy("timeout", 32'h100, 32'h240, 4, cyc, b1);
        checks++;
        if (cyc != 11 || error !== 1'b1 || words_done !== 16'd1) begin
            failures++; $display("FAIL timeout_status: done_cycle=%0d error=%0b wd=%0d, required 11/1/1", cyc, error, words_done);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (last_stall != 8 || n_valid != 10 || mem_valid !== 1'b0) begin
            failures++; $display("FAIL timeout_drop: stalled_valid=%0d valid_cycles=%0d valid_now=%0b, required 8/10/0", last_stall, n_valid, mem_valid);
        end
        m = mem_mismatches();
        checks++;
        if (m != 0) begin failures++; $display("FAIL timeout_ram: %0d words differ, required 0", m); end
        stall_rd = -1;
        snapshot(); model_copy(32'h100, 32'h240, 2);
        run_copy("timeout_recover", 32'h100, 32'h240, 2, cyc, b1);
        checks++;
        if (error !== 1'b0 || words_done !== 16'd2 || mem_mismatches() != 0) begin
            failures++; $display("FAIL timeout_recover: error=%0b wd=%0d, required 0/2 with correct copy", error, words_done);
        end
    endtask

    task automatic test_reset_midcopy();
        int k; int cyc; logic b1;
        fix_lat = 2; rand_lat = 1'b0; stall_rd = -1;
        kick(32'h100, 32'h500, 4);
        k = 0;
        while (!(n_wr == 1 && mem_valid && mem_wstrb == 4'hF) && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 200) begin failures++; $display("FAIL midreset_reach: second write not seen in %0d cycles", k); end
        resetn = 1'b0;
        #1;
        checks++;
        if ({mem_valid, mem_addr, mem_wdata, mem_wstrb, busy, done, error, words_done} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: valid=%0b addr=%h wdata=%h wstrb=%h busy=%0b done=%0b err=%0b wd=%0d, required all 0",
                     mem_valid, mem_addr, mem_wdata, mem_wstrb, busy, done, error, words_done);
        end
        @(negedge clk);
        resetn = 1'b1;
        fix_lat = 0;
        snapshot(); model_copy(32'h100, 32'h500, 4);
        run_copy("midreset_restart", 32'h100, 32'h500, 4, cyc, b1);
        checks++;
        if (cyc != 9 || error !== 1'b0 || words_done !== 16'd4 || mem_mismatches() != 0) begin
            failures++; $display("FAIL midreset_restart: done_cycle=%0d error=%0b wd=%0d, required 9/0/4 with correct copy", cyc, error, words_done);
        end
    endtask

    task automatic test_start_ignored();
        int cyc; logic b1; int m;
        fix_lat = 1; rand_lat = 1'b0; stall_rd = -1;
        snapshot(); model_copy(32'h600, 32'h700, 4);
        kick(32'h600, 32'h700, 4);
        repeat (2) @(negedge clk);
        src_addr = 32'h680; dst_addr = 32'h780; len_words = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignored", cyc);
        m = log_mismatches(32'h600, 32'h700, 4) + mem_mismatches();
        checks++;
        if (m != 0 || words_done !== 16'd4 || error !== 1'b0) begin
            failures++; $display("FAIL busy_start_ignored: mismatches=%0d wd=%0d error=%0b, required 0/4/0", m, words_done, error);
        end
        // start raised while in DONE must not launch a new copy
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL done_start_ignored: mem_valid=%0b busy=%0b, required 0/0", mem_valid, busy);
        end
        fix_lat = 0;
        ram[1023] = $urandom; ram[0] = $urandom;
        snapshot(); model_copy(32'hFFFF_FFFC, 32'h800, 2);
        run_copy("wrap", 32'hFFFF_FFFC, 32'h800, 2, cyc, b1);
        checks++;
        if (hs_addr.size() < 3 || hs_addr[2] !== 32'h0000_0000) begin
            failures++; $display("FAIL wrap_addr: second read addr=%h, required 00000000", (hs_addr.size() > 2) ? hs_addr[2] : 32'hx);
        end
        m = log_mismatches(32'hFFFF_FFFC, 32'h800, 2) + mem_mismatches();
        checks++;
        if (m != 0 || error !== 1'b0) begin
            failures++; $display("FAIL wrap_copy: mismatches=%0d error=%0b, required 0/0", m, error);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_random();
        test_misalign();
        test_timeout();
        test_reset_midcopy();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
